// File: rtl/dvi_ctrl_pkg.sv
// Shared constants for the DVI timing controller: state encoding, black pixel,
// counter width and the sync polarity helper.
package dvi_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_RESYNC = 2'd3;

    localparam logic [23:0] PIX_BLACK = 24'h000000;

    // Wide enough for any common video mode up to 4095 clocks or lines.
    localparam int CNT_W = 12;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
    } rgb_t;

    // Output pin level for a sync pulse: pol=1 passes it through, pol=0 inverts it.
    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ~^ pol;
    endfunction

endpackage

// File: rtl/dvi_timing_gen.sv
// Free-running raster counters with active-region and raw (active-high) sync decode.
// Regions run active, front porch, sync, back porch, starting at count 0.
module dvi_timing_gen
    import dvi_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             active,
    output logic             hsync,
    output logic             vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == CNT_W'(H_TOTAL - 1)) begin
            hc <= '0;
            vc <= (vc == CNT_W'(V_TOTAL - 1)) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign active = (hc < CNT_W'(H_ACTIVE)) && (vc < CNT_W'(V_ACTIVE));
    assign hsync  = (hc >= CNT_W'(H_ACTIVE + H_FP)) && (hc < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync  = (vc >= CNT_W'(V_ACTIVE + V_FP)) && (vc < CNT_W'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/dvi_timing_ctrl.sv
// DVI output controller: aligns an incoming SOF-marked pixel stream to the raster,
// blanks and resynchronises on underflow or misaligned SOF.
module dvi_timing_ctrl
    import dvi_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [23:0] PIX_DATA,
    input  logic        PIX_SOF,
    input  logic        PIX_VALID,
    output logic        PIX_READY,
    output logic [7:0]  TX_RED,
    output logic [7:0]  TX_GRN,
    output logic [7:0]  TX_BLU,
    output logic        TX_HS,
    output logic        TX_VS,
    output logic        TX_DE,
    output logic        FRAME_START,
    output logic        UNDERFLOW,
    output logic [1:0]  STATE
);

    logic [CNT_W-1:0] hc, vc;
    logic             active, hsync, vsync;
    logic [1:0]       state, state_nxt;
    logic             at_origin, abort, ready_p0, show_p0, uflow_p0;
    rgb_t             pix_p1;
    logic             de_p1, hs_p1, vs_p1, fs_p1, uflow_p1;

    dvi_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .CLK    (CLK),
        .RESET  (RESET),
        .hc     (hc),
        .vc     (vc),
        .active (active),
        .hsync  (hsync),
        .vsync  (vsync)
    );

    assign at_origin = (hc == '0) && (vc == '0);
    // ENABLE low at frame start overrides every other transition, including an SOF accept.
    assign abort     = at_origin && !ENABLE;

    // Stage p0: decide handshake, display and next state from the current raster position
    always_comb begin
        state_nxt = state;
        ready_p0  = 1'b0;
        show_p0   = 1'b0;
        uflow_p0  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (at_origin && ENABLE) state_nxt = ST_SYNC;
            end
            ST_SYNC, ST_RESYNC: begin
                ready_p0 = PIX_VALID && (!PIX_SOF || at_origin);
                if (PIX_VALID && PIX_SOF && at_origin) begin
                    show_p0   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                ready_p0 = active;
                if (active) begin
                    if (!PIX_VALID) begin
                        uflow_p0  = 1'b1;
                        state_nxt = ST_RESYNC;
                    end else begin
                        show_p0 = 1'b1;
                        if (PIX_SOF != at_origin) begin
                            uflow_p0  = 1'b1;
                            state_nxt = ST_RESYNC;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            ready_p0  = 1'b0;
            show_p0   = 1'b0;
            uflow_p0  = 1'b0;
            state_nxt = ST_IDLE;
        end
    end

    assign PIX_READY = ready_p0 && !RESET;

    // Stage p1: registered encoder-facing outputs, one cycle behind (hc,vc)
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            pix_p1   <= rgb_t'(PIX_BLACK);
            de_p1    <= 1'b0;
            hs_p1    <= sync_level(1'b0, HS_POL);
            vs_p1    <= sync_level(1'b0, VS_POL);
            fs_p1    <= 1'b0;
            uflow_p1 <= 1'b0;
        end else begin
            state    <= state_nxt;
            pix_p1   <= (show_p0 && active) ? rgb_t'(PIX_DATA) : rgb_t'(PIX_BLACK);
            de_p1    <= active;
            hs_p1    <= sync_level(hsync, HS_POL);
            vs_p1    <= sync_level(vsync, VS_POL);
            fs_p1    <= at_origin;
            uflow_p1 <= uflow_p0;
        end
    end

    assign TX_RED      = pix_p1.red;
    assign TX_GRN      = pix_p1.grn;
    assign TX_BLU      = pix_p1.blu;
    assign TX_DE       = de_p1;
    assign TX_HS       = hs_p1;
    assign TX_VS       = vs_p1;
    assign FRAME_START = fs_p1;
    assign UNDERFLOW   = uflow_p1;
    assign STATE       = state;

endmodule
